scs8hd_mux2_arb: RTL and testbench

Registered two-source round-robin arbiter that generates the select `S` for a downstream `scs8hd_mux2_*` cell and grants one of two requesters at a time. It feeds the mux's `A0`/`A1` path owners with grants and holds `S` stable for the length of a burst. It also inserts a programmable dead gap before `S` flips between back-to-back owners, so the mux output `X` is never consumed while its select is settling.

---
 rtl/scs8hd_mux2_arb.sv | 250 +++++++++++++++++++++++++
 tb/tb_scs8hd_mux2_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_mux2_arb.sv
// ============================================================================
// scs8hd_mux2_arb
// ----------------------------------------------------------------------------
// Purpose:
//   Registered two-source round-robin arbiter that drives the select S of a
//   downstream scs8hd_mux2_* cell. Each source gets grant bursts (one beat per
//   cycle in which it holds the grant and requests). Between back-to-back
//   owners the arbiter can insert GAP dead cycles, so the mux output is never
//   consumed while its select is settling.
//
// Parameters:
//   BURST_MAX  beats per grant before a forced hand-over while the other
//              source is waiting (1..255)
//   GAP        dead cycles between back-to-back owners (0..15)
//
// Ports:
//   CLK     in   clock, rising-edge active
//   RESETB  in   synchronous active-low reset
//   REQ0    in   source 0 (mux A0) request / beat available
//   REQ1    in   source 1 (mux A1) request / beat available
//   LAST0   in   source-0 beat is the last of its burst (qualified by beat)
//   LAST1   in   source-1 beat is the last of its burst (qualified by beat)
//   GNT0    out  source 0 owns the mux (registered)
//   GNT1    out  source 1 owns the mux (registered)
//   S       out  mux select, 0 = A0, 1 = A1 (registered)
//   VLD     out  mux output carries a valid beat this cycle (combinational)
//   BUSY    out  arbiter is not idle (registered)
// ============================================================================
module scs8hd_mux2_arb #(
    parameter int BURST_MAX = 8,
    parameter int GAP       = 1
) (
    input  logic CLK,
    input  logic RESETB,
    input  logic REQ0,
    input  logic REQ1,
    input  logic LAST0,
    input  logic LAST1,
    output logic GNT0,
    output logic GNT1,
    output logic S,
    output logic VLD,
    output logic BUSY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              BW     = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]   BMAX   = BW'(BURST_MAX);
    localparam logic [3:0]      GAP_LD = 4'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAPW = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [BW-1:0]   r_bcnt;
    logic [3:0]      r_gcnt;
    logic            r_last_owner;
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_s;
    logic            r_busy;

    // ------------------------------------------------------------------------
    // Next-state / combinational wires
    // ------------------------------------------------------------------------
    state_t          w_state_next;
    logic [BW-1:0]   w_bcnt_next;
    logic [3:0]      w_gcnt_next;
    logic            w_last_owner_next;
    logic            w_gnt0_next;
    logic            w_gnt1_next;
    logic            w_s_next;
    logic            w_busy_next;

    logic [1:0]      w_req;
    logic [1:0]      w_last;
    logic [1:0]      w_gnt;
    logic [1:0]      w_beat;

    logic            w_own;        // current owner index x while in an OWN state
    logic            w_req_x;
    logic            w_req_y;
    logic            w_last_x;
    logic            w_beat_x;
    logic [BW-1:0]   w_bcnt_inc;
    logic            w_at_max;
    logic            w_burst_end;
    logic            w_winner;
    logic            w_gap_src;    // source waiting for the mux while in GAPW
    logic            w_gap_done;

    // Per-source vectors so the owner's signals can be picked by index.
    assign w_req  = {REQ1,  REQ0};
    assign w_last = {LAST1, LAST0};
    assign w_gnt  = {r_gnt1, r_gnt0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_beat
            assign w_beat[gi] = w_gnt[gi] & w_req[gi];
        end
    endgenerate

    assign w_own      = (r_state == ST_OWN1);
    assign w_req_x    = w_req[w_own];
    assign w_req_y    = w_req[~w_own];
    assign w_last_x   = w_last[w_own];
    assign w_beat_x   = w_beat[w_own];
    assign w_bcnt_inc = r_bcnt + 1'b1;
    assign w_at_max   = w_beat_x && (w_bcnt_inc == BMAX);

    // The source that did not own the last burst is the one waiting in GAPW.
    assign w_gap_src  = ~r_last_owner;
    // A count of 0 is treated like 1 so a stray value can never stall GAPW.
    assign w_gap_done = (r_gcnt <= 4'd1);

    // ------------------------------------------------------------------------
    // Process 1: state register (all state, including registered outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            r_state      <= ST_IDLE;
            r_bcnt       <= '0;
            r_gcnt       <= '0;
            r_last_owner <= 1'b1;   // so source 0 wins the first tie
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_s          <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bcnt       <= w_bcnt_next;
            r_gcnt       <= w_gcnt_next;
            r_last_owner <= w_last_owner_next;
            r_gnt0       <= w_gnt0_next;
            r_gnt1       <= w_gnt1_next;
            r_s          <= w_s_next;
            r_busy       <= w_busy_next;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_bcnt_next       = r_bcnt;
        w_gcnt_next       = r_gcnt;
        w_last_owner_next = r_last_owner;
        w_burst_end       = 1'b0;
        w_winner          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Tie goes to whichever source did not own the last burst.
                if (REQ0 && REQ1) begin
                    w_winner = ~r_last_owner;
                end else begin
                    w_winner = REQ1;
                end
                if (REQ0 || REQ1) begin
                    w_state_next = w_winner ? ST_OWN1 : ST_OWN0;
                    w_bcnt_next  = '0;
                end
            end

            ST_OWN0, ST_OWN1: begin
                if (!w_req_x) begin
                    // Owner withdrew: release without a beat.
                    w_burst_end = 1'b1;
                end else if (w_last_x || (w_at_max && w_req_y)) begin
                    // LAST and the limit on the same beat are one burst end.
                    w_burst_end = 1'b1;
                end else if (w_at_max) begin
                    // Nobody else waiting: start a fresh burst window.
                    w_bcnt_next = '0;
                end else begin
                    w_bcnt_next = w_bcnt_inc;
                end

                if (w_burst_end) begin
                    w_last_owner_next = w_own;
                    w_bcnt_next       = '0;
                    if (w_req_y) begin
                        if (GAP > 0) begin
                            w_state_next = ST_GAPW;
                            w_gcnt_next  = GAP_LD;
                        end else begin
                            // Zero gap: grant and select swap on this edge.
                            w_state_next = w_own ? ST_OWN0 : ST_OWN1;
                        end
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_GAPW: begin
                // Requests are only looked at when the gap expires.
                if (w_gap_done) begin
                    w_gcnt_next = '0;
                    if (w_req[w_gap_src]) begin
                        w_state_next = w_gap_src ? ST_OWN1 : ST_OWN0;
                        w_bcnt_next  = '0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_gcnt_next = r_gcnt - 4'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output logic
    // Registered outputs are decoded from the next state; S only moves when
    // an OWN state is entered, so it holds through GAPW and IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt0_next = (w_state_next == ST_OWN0);
        w_gnt1_next = (w_state_next == ST_OWN1);
        w_busy_next = (w_state_next != ST_IDLE);
        w_s_next    = r_s;
        if (w_state_next == ST_OWN0) begin
            w_s_next = 1'b0;
        end else if (w_state_next == ST_OWN1) begin
            w_s_next = 1'b1;
        end
        VLD = |w_beat;
    end

    assign GNT0 = r_gnt0;
    assign GNT1 = r_gnt1;
    assign S    = r_s;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_scs8hd_mux2_arb.sv
// ============================================================================
// tb_scs8hd_mux2_arb
// ----------------------------------------------------------------------------
// Directed bench for scs8hd_mux2_arb. Four instances share the stimulus, each
// with its own BURST_MAX/GAP; every scenario observes one of them. Expected
// {GNT0,GNT1,S,BUSY} is queued when a cycle's inputs are driven and compared
// after the edge; VLD is checked before the edge from the previous expected
// grants and the inputs just driven.
// ============================================================================
module tb_scs8hd_mux2_arb;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESETB = 1'b0;
    logic REQ0   = 1'b0;
    logic REQ1   = 1'b0;
    logic LAST0  = 1'b0;
    logic LAST1  = 1'b0;

    logic [3:0] gnt0;
    logic [3:0] gnt1;
    logic [3:0] sel_o;
    logic [3:0] vld;
    logic [3:0] busy;

    // Instance 0: defaults (8,1); 1: (4,1); 2: (4,0); 3: (4,3)
    localparam int DUT_D = 0;
    localparam int DUT_A = 1;
    localparam int DUT_B = 2;
    localparam int DUT_C = 3;

    scs8hd_mux2_arb u_dut_d (
        .CLK(CLK), .RESETB(RESETB), .REQ0(REQ0), .REQ1(REQ1),
        .LAST0(LAST0), .LAST1(LAST1),
        .GNT0(gnt0[0]), .GNT1(gnt1[0]), .S(sel_o[0]), .VLD(vld[0]), .BUSY(busy[0])
    );

    scs8hd_mux2_arb #(.BURST_MAX(4), .GAP(1)) u_dut_a (
        .CLK(CLK), .RESETB(RESETB), .REQ0(REQ0), .REQ1(REQ1),
        .LAST0(LAST0), .LAST1(LAST1),
        .GNT0(gnt0[1]), .GNT1(gnt1[1]), .S(sel_o[1]), .VLD(vld[1]), .BUSY(busy[1])
    );

    scs8hd_mux2_arb #(.BURST_MAX(4), .GAP(0)) u_dut_b (
        .CLK(CLK), .RESETB(RESETB), .REQ0(REQ0), .REQ1(REQ1),
        .LAST0(LAST0), .LAST1(LAST1),
        .GNT0(gnt0[2]), .GNT1(gnt1[2]), .S(sel_o[2]), .VLD(vld[2]), .BUSY(busy[2])
    );

    scs8hd_mux2_arb #(.BURST_MAX(4), .GAP(3)) u_dut_c (
        .CLK(CLK), .RESETB(RESETB), .REQ0(REQ0), .REQ1(REQ1),
        .LAST0(LAST0), .LAST1(LAST1),
        .GNT0(gnt0[3]), .GNT1(gnt1[3]), .S(sel_o[3]), .VLD(vld[3]), .BUSY(busy[3])
    );

    // Expected {GNT0,GNT1,S,BUSY}
    localparam logic [3:0] E_IDLE0 = 4'b0000;
    localparam logic [3:0] E_IDLE1 = 4'b0010;
    localparam logic [3:0] E_OWN0  = 4'b1001;
    localparam logic [3:0] E_OWN1  = 4'b0111;
    localparam logic [3:0] E_GAP0  = 4'b0001;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_t;

    sb_t        sb_q[$];
    int         n_cmp     = 0;
    int         n_err     = 0;
    int         sel       = 0;
    logic [3:0] prev_exp  = 4'b0000;
    bit         have_prev = 1'b0;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] dut_vec(input int k);
        return {gnt0[k], gnt1[k], sel_o[k], busy[k]};
    endfunction

    // One clock cycle: drive inputs, check VLD, queue the post-edge
    // expectation, clock, then pop and compare.
    task automatic cyc(input string tag, input logic r0, input logic r1,
                       input logic l0, input logic l1, input logic [3:0] exp);
        sb_t  e;
        sb_t  got_e;
        logic exp_vld;
        REQ0  = r0;
        REQ1  = r1;
        LAST0 = l0;
        LAST1 = l1;
        #1;
        if (have_prev) begin
            exp_vld = (prev_exp[3] & r0) | (prev_exp[2] & r1);
            check({tag, ".vld"}, {3'b000, vld[sel]}, {3'b000, exp_vld});
        end
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        got_e = sb_q.pop_front();
        check(got_e.tag, dut_vec(sel), got_e.exp);
        $display("%0t %s rstb=%b req=%b%b last=%b%b out=%b exp=%b",
                 $time, got_e.tag, RESETB, r1, r0, l1, l0, dut_vec(sel), got_e.exp);
        prev_exp  = exp;
        have_prev = 1'b1;
    endtask

    task automatic do_reset(input int k, input string tag);
        sel    = k;
        RESETB = 1'b0;
        cyc({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE0);
        RESETB = 1'b1;
    endtask

    initial begin
        // 1. Single requester, 3 beats with LAST on beat 3
        do_reset(DUT_D, "t1");
        cyc("t1.grant", 1, 0, 0, 0, E_OWN0);
        cyc("t1.b1",    1, 0, 0, 0, E_OWN0);
        cyc("t1.b2",    1, 0, 0, 0, E_OWN0);
        cyc("t1.b3",    1, 0, 1, 0, E_IDLE0);
        cyc("t1.idle",  0, 0, 0, 0, E_IDLE0);

        // 2. Tie after reset, GAP=1 hand-over, round-robin on later ties
        do_reset(DUT_D, "t2");
        cyc("t2.tie",    1, 1, 0, 0, E_OWN0);
        cyc("t2.last0",  1, 1, 1, 0, E_GAP0);
        cyc("t2.gap",    0, 1, 0, 0, E_OWN1);
        cyc("t2.last1",  0, 1, 0, 1, E_IDLE1);
        cyc("t2.tie2",   1, 1, 0, 0, E_OWN0);
        cyc("t2.rel0",   1, 0, 1, 0, E_IDLE0);
        cyc("t2.tie3",   1, 1, 0, 0, E_OWN1);
        cyc("t2.rel1",   0, 1, 0, 1, E_IDLE1);
        cyc("t2.idle",   0, 0, 0, 0, E_IDLE1);

        // 3. Preemption at BURST_MAX=4, then continuous ownership when alone
        do_reset(DUT_A, "t3");
        cyc("t3.tie",  1, 1, 0, 0, E_OWN0);
        cyc("t3.b1",   1, 1, 0, 0, E_OWN0);
        cyc("t3.b2",   1, 1, 0, 0, E_OWN0);
        cyc("t3.b3",   1, 1, 0, 0, E_OWN0);
        cyc("t3.b4",   1, 1, 0, 0, E_GAP0);
        cyc("t3.gap",  1, 1, 0, 0, E_OWN1);
        cyc("t3.rel1", 0, 1, 0, 1, E_IDLE1);
        cyc("t3.solo", 1, 0, 0, 0, E_OWN0);
        for (int i = 1; i <= 6; i++) begin
            cyc($sformatf("t3.s%0d", i), 1, 0, 0, 0, E_OWN0);
        end
        cyc("t3.last", 1, 0, 1, 0, E_IDLE0);

        // 4. GAP=0 back-to-back swap
        do_reset(DUT_B, "t4");
        cyc("t4.tie",   1, 1, 0, 0, E_OWN0);
        cyc("t4.swap",  1, 1, 1, 0, E_OWN1);
        cyc("t4.b1",    0, 1, 0, 0, E_OWN1);
        cyc("t4.last1", 0, 1, 0, 1, E_IDLE1);
        cyc("t4.idle",  0, 0, 0, 0, E_IDLE1);

        // 5. GAP=3, waiting source withdraws in the 2nd gap cycle
        do_reset(DUT_C, "t5");
        cyc("t5.tie",   1, 1, 0, 0, E_OWN0);
        cyc("t5.last0", 1, 1, 1, 0, E_GAP0);
        cyc("t5.gap1",  0, 1, 0, 0, E_GAP0);
        cyc("t5.gap2",  0, 0, 0, 0, E_GAP0);
        cyc("t5.gap3",  0, 0, 0, 0, E_IDLE0);
        cyc("t5.idle",  0, 0, 0, 0, E_IDLE0);

        // 6. Reset at beat 2 of source 1, next tie goes to source 0
        do_reset(DUT_A, "t6");
        cyc("t6.grant1", 0, 1, 0, 0, E_OWN1);
        cyc("t6.b1",     0, 1, 0, 0, E_OWN1);
        RESETB = 1'b0;
        cyc("t6.midrst", 0, 1, 0, 0, E_IDLE0);
        RESETB = 1'b1;
        cyc("t6.tie",    1, 1, 0, 0, E_OWN0);
        cyc("t6.last0",  1, 0, 1, 0, E_IDLE0);
        cyc("t6.idle",   0, 0, 0, 0, E_IDLE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
